co2_code_transmitter: RTL and testbench



---
 rtl/co2_code_transmitter.sv | 98 +++++++++
 tb/tb_co2_code_transmitter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/co2_code_transmitter.sv
// co2_code_transmitter: shifts a fixed code frame MSB-first onto x_out, N times with zero gaps.
// Define CO2TX_ABORT_EN to add an abort input that ends a transmission early.
module co2_code_transmitter #(
  parameter int CODE_LEN = 9,
  parameter logic [CODE_LEN-1:0] CODE = 9'b100100100,
  parameter int GAP_TICKS = 2,
  parameter int REPEAT_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tick,
  input  logic                start,
  input  logic [REPEAT_W-1:0] repeat_cnt,
`ifdef CO2TX_ABORT_EN
  input  logic                abort,
`endif
  output logic                x_out,
  output logic                busy,
  output logic                done,
  output logic [REPEAT_W-1:0] frame_cnt
);
  localparam int BW = $clog2(CODE_LEN);
  localparam int GW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state;
  logic [CODE_LEN-2:0] sh;
  logic [BW-1:0] bit_idx;
  logic [GW-1:0] gap_cnt;
  logic [REPEAT_W-1:0] rem;
  logic kill;
`ifdef CO2TX_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  // sh holds the bits still to be sent after the one currently on x_out
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      sh        <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      rem       <= '0;
      x_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          rem       <= (repeat_cnt == '0) ? REPEAT_W'(1) : repeat_cnt;
          sh        <= CODE[CODE_LEN-2:0];
          x_out     <= CODE[CODE_LEN-1];
          bit_idx   <= '0;
          busy      <= 1'b1;
          frame_cnt <= '0;
          state     <= SHIFT;
        end
      end else if (kill) begin
        state <= IDLE;
        x_out <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else if (tick) begin
        if (state == GAP) begin
          if (gap_cnt == GW'(GAP_TICKS - 1)) begin
            sh      <= CODE[CODE_LEN-2:0];
            x_out   <= CODE[CODE_LEN-1];
            bit_idx <= '0;
            state   <= SHIFT;
          end else gap_cnt <= gap_cnt + 1'b1;
        end else if (bit_idx != BW'(CODE_LEN - 1)) begin
          x_out   <= sh[CODE_LEN-2];
          sh      <= sh << 1;
          bit_idx <= bit_idx + 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
          rem       <= rem - 1'b1;
          if (rem == REPEAT_W'(1)) begin
            state <= IDLE;
            x_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (GAP_TICKS > 0) begin
            state   <= GAP;
            x_out   <= 1'b0;
            gap_cnt <= '0;
          end else begin
            sh      <= CODE[CODE_LEN-2:0];
            x_out   <= CODE[CODE_LEN-1];
            bit_idx <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_co2_code_transmitter.sv
// tb_co2_code_transmitter: directed scoreboard bench; expected x_out stream is queued per
// transmission from the code pattern and popped as the line advances.
module tb_co2_code_transmitter;
  localparam int GAP = 2;
  logic CLK = 1'b0;
  logic RST, tick, start, x_out, busy, done;
  logic [3:0] repeat_cnt, frame_cnt;
`ifdef CO2TX_ABORT_EN
  logic abort;
`endif
  logic [8:0] code_v = 9'b100100100;
  logic q[$];
  int checks = 0, passes = 0;

  co2_code_transmitter dut (
    .CLK(CLK), .RST(RST), .tick(tick), .start(start), .repeat_cnt(repeat_cnt),
`ifdef CO2TX_ABORT_EN
    .abort(abort),
`endif
    .x_out(x_out), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) passes = passes + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
  endtask

  task automatic idle(input int c);
    start = 1'b0;
    for (int i = 0; i < c; i++) begin
      @(negedge CLK);
      chk("idle_done", {7'd0, done}, 8'd0);
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("idle_x", {7'd0, x_out}, 8'd0);
    end
  endtask

  // Drives one transmission from the current negedge; tick on every p-th edge from the start edge.
  task automatic xmit(input int rep, input int p, input int nf, input bit poke);
    int n;
    q.delete();
    for (int f = 0; f < nf; f++) begin
      for (int b = 8; b >= 0; b--) repeat (p) q.push_back(code_v[b]);
      if (f < nf - 1) repeat (GAP * p) q.push_back(1'b0);
    end
    n = q.size();
    for (int k = 0; k <= n; k++) begin
      start = (k == 0) || (poke && (k == 5 || k == n));
      repeat_cnt = 4'(rep);
      tick = (k % p == 0);
      @(negedge CLK);
      if (k < n) begin
        chk("x_out", {7'd0, x_out}, {7'd0, q.pop_front()});
        chk("busy", {7'd0, busy}, 8'd1);
        chk("done_early", {7'd0, done}, 8'd0);
      end else begin
        chk("done", {7'd0, done}, 8'd1);
        chk("busy_end", {7'd0, busy}, 8'd0);
        chk("x_end", {7'd0, x_out}, 8'd0);
        chk("frame_cnt", {4'd0, frame_cnt}, 8'(nf));
      end
    end
    start = 1'b0;
    tick = 1'b1;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; tick = 1'b0; repeat_cnt = '0;
`ifdef CO2TX_ABORT_EN
    abort = 1'b0;
`endif
    #1 RST = 1'b0;
    #1;
    chk("rst_x", {7'd0, x_out}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_fcnt", {4'd0, frame_cnt}, 8'd0);
    @(negedge CLK) RST = 1'b1;
    idle(2);
    // reset in the middle of a frame clears everything without a clock edge
    for (int k = 0; k < 4; k++) begin
      start = (k == 0); repeat_cnt = 4'd1; tick = 1'b1;
      @(negedge CLK);
    end
    chk("pre_rst_x", {7'd0, x_out}, 8'd1);
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    #2 RST = 1'b0;
    #1;
    chk("async_x", {7'd0, x_out}, 8'd0);
    chk("async_busy", {7'd0, busy}, 8'd0);
    chk("async_fcnt", {4'd0, frame_cnt}, 8'd0);
    @(negedge CLK) RST = 1'b1;
    idle(12);
    xmit(1, 1, 1, 1'b0);
    idle(2);
    xmit(3, 1, 3, 1'b0);
    idle(1);
    xmit(0, 3, 1, 1'b0);
    idle(1);
    // start while busy and on the done edge is dropped; the next edge's start is taken
    xmit(2, 1, 2, 1'b1);
    xmit(1, 1, 1, 1'b0);
    idle(2);
`ifdef CO2TX_ABORT_EN
    q.delete();
    for (int b = 8; b >= 0; b--) q.push_back(code_v[b]);
    repeat (GAP) q.push_back(1'b0);
    for (int b = 8; b >= 4; b--) q.push_back(code_v[b]);
    for (int k = 0; k < 16; k++) begin
      start = (k == 0); repeat_cnt = 4'd2; tick = 1'b1;
      @(negedge CLK);
      chk("ab_x", {7'd0, x_out}, {7'd0, q.pop_front()});
    end
    start = 1'b0; abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("ab_x_end", {7'd0, x_out}, 8'd0);
    chk("ab_done", {7'd0, done}, 8'd1);
    chk("ab_busy", {7'd0, busy}, 8'd0);
    chk("ab_fcnt", {4'd0, frame_cnt}, 8'd1);
    idle(2);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
